// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter and registered sequencer for the register file's single write port.
// The winner's address/data are captured and a one-hot row enable is issued; writes to ZERO_REG are discarded.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [2**ADDR_W-1:0]        wr_sel,
  output logic                        dropped
);
  localparam int PW   = $clog2(NUM_REQ);
  localparam int ROWS = 2**ADDR_W;
  logic [PW-1:0]     last, win;
  logic              found, grant, zero;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int                k;
  // Scan starts just past the last winner so every requester gets its turn.
  always_comb begin
    found    = 1'b0;
    win      = last;
    sel_addr = '0;
    sel_data = '0;
    k        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        win      = PW'(k);
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        sel_data = req_data[k*DATA_W +: DATA_W];
      end
    end
    grant = found && !stall;
    zero  = sel_addr == ADDR_W'(ZERO_REG);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_sel  <= '0;
      dropped <= 1'b0;
      last    <= PW'(NUM_REQ-1);
    end else begin
      gnt     <= grant ? NUM_REQ'(1) << win : '0;
      wr_en   <= grant && !zero;
      wr_sel  <= (grant && !zero) ? ROWS'(1) << sel_addr : '0;
      dropped <= grant && zero;
      if (grant) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        last    <= win;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus a randomized reference-model run for the write-port arbiter.
module tb_regfile_write_arbiter;
  localparam int N = 4, AW = 5, DW = 64, ROWS = 32;
  logic            clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            wr_en, dropped;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [ROWS-1:0] wr_sel;
  logic [106:0]    obs, ex;
  int              checks = 0, errors = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel), .dropped(dropped)
  );

  always #5 clk = ~clk;
  assign obs = {gnt, wr_en, wr_addr, wr_data, wr_sel, dropped};

  function automatic logic [106:0] pack(input logic [3:0] g, input logic en, input logic [4:0] a,
                                        input logic [63:0] d, input logic [31:0] s, input logic dr);
    return {g, en, a, d, s, dr};
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 4'b1111;
    set_req(0, 5'd1, 64'h1);
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
  endtask

  task automatic test_single;
    do_reset();
    set_req(0, 5'd3, 64'hA5);
    req = 4'b0001;
    @(posedge clk); #1;
    ex = pack(4'b0001, 1'b1, 5'd3, 64'hA5, 32'h8, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL single_grant: got %h want %h", obs, ex); end
    req = '0;
    @(posedge clk); #1;
    ex = pack(4'b0000, 1'b0, 5'd3, 64'hA5, 32'h0, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL single_idle: got %h want %h", obs, ex); end
  endtask

  task automatic test_all_rr;
    logic [3:0]  tg[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [4:0]  ta[4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [31:0] ts[4] = '{32'h2, 32'h4, 32'h8, 32'h10};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 64'h100 + 64'(i));
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      ex = pack(tg[c%4], 1'b1, ta[c%4], 64'h100 + 64'(c%4), ts[c%4], 1'b0);
      checks++;
      if (obs !== ex) begin errors++; $display("FAIL all_rr[%0d]: got %h want %h", c, obs, ex); end
    end
    req = '0;
  endtask

  task automatic test_zero_reg;
    do_reset();
    set_req(1, 5'd31, 64'h77);
    req = 4'b0010;
    @(posedge clk); #1;
    ex = pack(4'b0010, 1'b0, 5'd31, 64'h77, 32'h0, 1'b1);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL zero_drop: got %h want %h", obs, ex); end
    set_req(0, 5'd5, 64'h50);
    set_req(1, 5'd6, 64'h60);
    req = 4'b0011;
    @(posedge clk); #1;
    ex = pack(4'b0001, 1'b1, 5'd5, 64'h50, 32'h20, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL zero_ptr: got %h want %h", obs, ex); end
    req = '0;
  endtask

  task automatic test_stall;
    do_reset();
    set_req(0, 5'd7, 64'hC7);
    set_req(2, 5'd9, 64'hC9);
    req   = 4'b0101;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL stall_block[%0d]: got %h want 0", c, obs); end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    ex = pack(4'b0001, 1'b1, 5'd7, 64'hC7, 32'h80, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_first: got %h want %h", obs, ex); end
    @(posedge clk); #1;
    ex = pack(4'b0100, 1'b1, 5'd9, 64'hC9, 32'h200, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_second: got %h want %h", obs, ex); end
    stall = 1'b1;
    @(posedge clk); #1;
    ex = pack(4'b0000, 1'b0, 5'd9, 64'hC9, 32'h0, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL stall_hold: got %h want %h", obs, ex); end
    stall = 1'b0;
    req   = '0;
  endtask

  task automatic test_async_reset;
    do_reset();
    set_req(3, 5'd10, 64'hD3);
    req = 4'b1000;
    @(posedge clk); #1;
    ex = pack(4'b1000, 1'b1, 5'd10, 64'hD3, 32'h400, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL async_first: got %h want %h", obs, ex); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_clear: got %h want 0", obs); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL async_regrant: got %h want %h", obs, ex); end
    set_req(0, 5'd4, 64'hD0);
    req = 4'b1001;
    @(posedge clk); #1;
    ex = pack(4'b0001, 1'b1, 5'd4, 64'hD0, 32'h10, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL async_ptr0: got %h want %h", obs, ex); end
    @(posedge clk); #1;
    ex = pack(4'b1000, 1'b1, 5'd10, 64'hD3, 32'h400, 1'b0);
    checks++;
    if (obs !== ex) begin errors++; $display("FAIL async_ptr3: got %h want %h", obs, ex); end
    req = '0;
  endtask

  task automatic test_random;
    int          ml = N - 1, w, max_wait = 0;
    int          wt[N];
    logic [3:0]  eg;
    logic        een, edr, inv;
    logic [4:0]  ea = '0;
    logic [63:0] ed = '0;
    logic [31:0] es;
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      req   = 4'($urandom);
      stall = $urandom_range(0, 3) == 0;
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom), {$urandom, $urandom});
      eg = '0; een = 1'b0; es = '0; edr = 1'b0; w = -1;
      if (!stall && req != '0) begin
        for (int n = 1; n <= N; n++)
          if (w < 0 && req[(ml + n) % N]) w = (ml + n) % N;
        eg  = 4'(1 << w);
        ea  = req_addr[w*AW +: AW];
        ed  = req_data[w*DW +: DW];
        edr = ea == 5'd31;
        een = !edr;
        es  = een ? 32'(1) << ea : '0;
        ml  = w;
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i]) wt[i] = 0;
        else if (!stall) wt[i] = (w == i) ? 0 : wt[i] + 1;
        if (wt[i] > max_wait) max_wait = wt[i];
      end
      @(posedge clk); #1;
      ex = pack(eg, een, ea, ed, es, edr);
      checks++;
      if (obs !== ex) begin errors++; $display("FAIL random[%0d]: got %h want %h", c, obs, ex); end
      inv = $onehot0(gnt) && $onehot0(wr_sel) && (wr_en == |wr_sel) && (!wr_en || |gnt) && !wr_sel[31];
      checks++;
      if (!inv) begin errors++; $display("FAIL invariant[%0d]: gnt=%b wr_en=%b wr_sel=%h", c, gnt, wr_en, wr_sel); end
    end
    checks++;
    if (max_wait >= N) begin errors++; $display("FAIL starvation: got wait %0d want < %0d", max_wait, N); end
    req   = '0;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_zero_reg();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin arbiter and write sequencer for the shared single write port of the register file.
- The register file is built from enabled bit registers that hold their value while their enable is low.
- Up to NUM_REQ requesters (ALU writeback, load return, link-register write, debug) compete for the port.
- The block registers the winner's address and data, and drives a one-hot row-enable vector. Each bit of that vector feeds the enable of one register row.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 64, register data width.
- ADDR_W, 5, register address width; the file has 2^ADDR_W rows.
- ZERO_REG, 31, hardwired-zero register index; writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; while high, no grant is issued.
- req  input  NUM_REQ  per-requester write request, level.
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i uses slice i.
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i uses slice i.
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
- wr_en  output  1  write-port valid.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- wr_sel  output  2^ADDR_W  one-hot row enable; all zero when wr_en=0.
- dropped  output  1  one-cycle pulse: the granted write targeted ZERO_REG.

Behaviour:
- All outputs are registered.
- Reset, asynchronous:
  - gnt=0, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, dropped=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has highest priority first.
- Arbitration at each rising edge, when stall=0 and |req=1:
  - Winner w is the first asserted req scanning last+1, last+2, … modulo NUM_REQ.
  - Next cycle: gnt=1<<w, wr_addr=req_addr[w], wr_data=req_data[w], last<=w.
- Latency: request sampled at edge k → gnt, wr_en, wr_sel valid in cycle k+1 → register row captures at edge k+1.
- The gnt pulse acknowledges that addr/data were captured at edge k.
  - A requester drops req in cycle k+1 if it has no further write.
  - req still high in cycle k+1 is a new request.
  - A continuous requester therefore gets at most one grant per NUM_REQ cycles when all requesters are active.
  - A lone requester is granted every cycle: 100% port throughput.
- Write enable and row select:
  - If req_addr[w] != ZERO_REG: wr_en=1 and wr_sel=1<<req_addr[w].
  - If req_addr[w] == ZERO_REG: gnt still pulses, wr_en=0, wr_sel=0, dropped=1, wr_addr/wr_data still updated.
- No request, or stall=1:
  - Next cycle gnt=0, wr_en=0, wr_sel=0, dropped=0.
  - wr_addr and wr_data hold their previous values.
  - Pointer holds.
- A stall asserted in cycle k only suppresses the grant decision at edge k. An already-issued grant (visible in cycle k) completes normally.
- Reset asserted mid-operation clears in-flight outputs immediately. The write in flight is lost, and the requester must re-request.
- Invariants to check:
  - gnt is one-hot or zero.
  - wr_sel is one-hot or zero.
  - wr_en equals |wr_sel.
  - wr_en=1 implies |gnt=1.
  - wr_sel[ZERO_REG] is never 1.

Test Plan:
- Reset, then req=4'b0001, addr0=3, data0=64'hA5 → one cycle after the edge: gnt=0001, wr_en=1, wr_addr=3, wr_sel=1<<3, wr_data=64'hA5; last=0.
- All four req held high for 8 cycles from reset → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; every cycle wr_en=1.
- req=4'b0010, addr1=31 → gnt=0010, wr_en=0, wr_sel=0, dropped=1; pointer advances to 1.
- req=4'b0101, stall=1 for 3 edges then 0 → no gnt during the stall; then gnt=0001 first, then 0100; wr_addr/wr_data unchanged during the stall.
- req=4'b1000 held from reset; assert reset one cycle after the first gnt → all outputs 0 asynchronously; after release, first grant goes to requester 3 again with last=3.
- Random req/addr/data for 10k cycles against a reference model → per-cycle match on gnt/wr_*; invariants hold; no starvation beyond NUM_REQ cycles.
